irrigation_sequencer: RTL and testbench
=======================================

// Module: irrigation_sequencer
// PURPOSE
//  Sequences the irrigation valves from the 2-bit irrigation type (00 none, 01 aspersion, 10 drip,
//  11 aspersion-then-drip) and the reservoir level sensors. Sits after the irrigation-type decoder.
//  Owns the timed aspersion phase of mode 11 and the reservoir-fill and level-error interlocks.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per second (prescaler terminal count + 1)
//  ASP_TIME       22          aspersion seconds in mode 11 before switching to drip
//  SEC_W          5           second-counter width; must hold ASP_TIME-1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  init           in   1  system enable; 0 forces IDLE (ERROR excepted)
//  irr_type       in   2  requested irrigation type (00/01/10/11 as above)
//  h_min          in   1  1 = water above minimum level
//  h_max          in   1  1 = water at or above maximum level
//  valve_asp      out  1  aspersion valve open
//  valve_drip     out  1  drip valve open
//  valve_fill     out  1  reservoir inlet valve open
//  error          out  1  level-sensor inconsistency flag
//  state          out  3  current FSM state code, for display
// BEHAVIOUR
//  - Reset: state=IDLE; all valves 0, error=0, prescaler=0, seconds=0.
//  - Moore outputs, all registered; inputs affect outputs one clk after sampling.
//  - States: IDLE=000, ASP=001, DRIP=010, MIX_ASP=011, FILL=100, ERR=101.
//    IDLE: all 0. ASP/MIX_ASP: valve_asp=1. DRIP: valve_drip=1. FILL: valve_fill=1. ERR: error=1.
//  - Priority each clk, evaluated from any state:
//    1) h_max=1 & h_min=0 -> ERR.
//    2) h_min=0 -> FILL.
//    3) init=0 -> IDLE.
//    4) Otherwise the irrigation rules below.
//  - ERR: held while sensors are inconsistent. Exit to IDLE requires consistent sensors and init=0.
//  - FILL: held until h_max=1, then IDLE. init=0 does not abort the fill.
//  - Irrigation rules, from IDLE:
//    - irr_type 01 -> ASP; 10 -> DRIP; 11 -> MIX_ASP; 00 -> stay IDLE.
//    - Entering MIX_ASP clears the prescaler and the seconds counter.
//  - ASP: stay while irr_type==01; otherwise IDLE.
//  - DRIP: stay while irr_type is 10 or 11; otherwise IDLE.
//    A MIX sequence therefore continues in DRIP.
//  - MIX_ASP timing:
//    - Prescaler counts 0..TICKS_PER_SEC-1 and wraps. Its wrap increments seconds.
//    - On the wrap with seconds==ASP_TIME-1 -> DRIP.
//    - MIX_ASP lasts exactly ASP_TIME*TICKS_PER_SEC clks.
//    - irr_type != 11 during MIX_ASP -> IDLE; counters freeze, cleared on next entry.
//  - Type change in ASP/DRIP always passes through one IDLE cycle. The asp and drip valves are never
//    both 1, and neither is ever 1 together with valve_fill.
//  - Reset mid-operation: immediate return to reset values; the timed phase restarts from 0.
//  - Counters count only in MIX_ASP; no arithmetic overflow is possible beyond the wrap.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE..ERR) and irr_type codes (NONE, ASP, DRIP, MIX),
//    also used by the display decoder.
//  - One sub-module: irr_sec_timer. Inputs clk, rst_n, clr, en. Outputs sec_tick, done.
//    Parameterised by TICKS_PER_SEC, ASP_TIME, SEC_W.
//  - The FSM, next-state logic and output register stay in this module.
// TESTING (TICKS_PER_SEC=4, ASP_TIME=3)
//  1) Reset, then h_min=1, h_max=1, init=1, irr_type=01 -> state=001, valve_asp=1 one clk later.
//     Set irr_type=00 -> IDLE, valves 0.
//  2) irr_type=11 held -> valve_asp=1 for exactly 12 clks, then valve_drip=1, state=010.
//     Drop to 00 -> IDLE.
//  3) irr_type=11 for 6 clks, then 00, then 11 again -> full 12-clk aspersion phase restarts.
//  4) During DRIP, h_min=0 -> FILL: valve_fill=1, drip=0.
//     h_min=1, h_max=1 -> IDLE, then DRIP again if irr_type=10.
//  5) h_max=1 & h_min=0 in any state -> ERR, error=1, all valves 0.
//     Stays ERR while init=1 with consistent sensors; init=0 -> IDLE.
//  6) rst_n pulsed low mid-MIX_ASP (asynchronous, between edges) -> outputs 0 at once.
//     After release, mode 11 gives a fresh 12-clk aspersion phase.

Source files
------------

// File: rtl/irrigation_sequencer_pkg.sv
// Shared encodings for the irrigation sequencer and the display decoder.
//   state_t : FSM state codes shown on the display
//   irr_t   : irrigation type codes from the irrigation-type decoder
//   outs_t  : registered valve/flag bundle, plus its decode from a state
package irrigation_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_ASP     = 3'b001,
    ST_DRIP    = 3'b010,
    ST_MIX_ASP = 3'b011,
    ST_FILL    = 3'b100,
    ST_ERR     = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    IRR_NONE = 2'b00,
    IRR_ASP  = 2'b01,
    IRR_DRIP = 2'b10,
    IRR_MIX  = 2'b11
  } irr_t;

  typedef struct packed {
    logic asp;
    logic drip;
    logic fill;
    logic err;
  } outs_t;

  // Moore decode: each state drives at most one output, so the valves are
  // mutually exclusive by construction.
  function automatic outs_t state_outs(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      ST_ASP, ST_MIX_ASP: o.asp  = 1'b1;
      ST_DRIP:            o.drip = 1'b1;
      ST_FILL:            o.fill = 1'b1;
      ST_ERR:             o.err  = 1'b1;
      default:            o      = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_timer.sv
// irr_sec_timer: prescaler + seconds counter for the timed aspersion phase.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both counters (wins over en)
//   en         : count enable
//   sec_tick   : prescaler is on its terminal count this cycle (and en)
//   done       : sec_tick on the last second (ASP_TIME-1)
module irr_sec_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ASP_TIME      = 22,
  parameter int SEC_W         = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sec_tick,
  output logic done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] secs;

  assign sec_tick = en && (presc == PW'(TICKS_PER_SEC - 1));
  assign done     = sec_tick && (secs == SEC_W'(ASP_TIME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      secs  <= '0;
    end else if (clr) begin
      presc <= '0;
      secs  <= '0;
    end else if (en) begin
      if (sec_tick) begin
        presc <= '0;
        // seconds wrap with the phase end so they never exceed ASP_TIME-1
        secs  <= done ? '0 : secs + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: valve sequencing FSM with reservoir interlocks.
//   clk, rst_n     : clock, async active-low reset
//   init           : system enable (0 forces IDLE, except from ERR/FILL)
//   irr_type       : requested irrigation type
//   h_min, h_max   : reservoir level sensors
//   valve_asp/drip/fill, error : registered Moore outputs
//   state          : current FSM state code
module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ASP_TIME      = 22,
  parameter int SEC_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic [1:0] irr_type,
  input  logic       h_min,
  input  logic       h_max,
  output logic       valve_asp,
  output logic       valve_drip,
  output logic       valve_fill,
  output logic       error,
  output logic [2:0] state
);

  state_t state_q, state_d;
  outs_t  outs_q;
  irr_t   typ;
  logic   tmr_clr, tmr_en, sec_tick, tmr_done;

  assign typ = irr_t'(irr_type);

  // Clear on the entry edge so MIX_ASP sees exactly ASP_TIME*TICKS_PER_SEC clks.
  assign tmr_clr = (state_d == ST_MIX_ASP) && (state_q != ST_MIX_ASP);
  assign tmr_en  = (state_q == ST_MIX_ASP);

  irr_sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .ASP_TIME     (ASP_TIME),
    .SEC_W        (SEC_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .sec_tick(sec_tick),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= state_outs(state_d);
    end
  end

  always_comb begin
    state_d = state_q;
    if (h_max && !h_min) begin
      state_d = ST_ERR;
    end else if (state_q == ST_ERR) begin
      // Sensors are consistent here; leaving also needs the operator to drop init.
      state_d = init ? ST_ERR : ST_IDLE;
    end else if (!h_min) begin
      state_d = ST_FILL;
    end else if (state_q == ST_FILL) begin
      // Fill ignores init and runs until the reservoir is full.
      state_d = h_max ? ST_IDLE : ST_FILL;
    end else if (!init) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (typ)
            IRR_ASP:  state_d = ST_ASP;
            IRR_DRIP: state_d = ST_DRIP;
            IRR_MIX:  state_d = ST_MIX_ASP;
            default:  state_d = ST_IDLE;
          endcase
        end
        ST_ASP:     state_d = (typ == IRR_ASP) ? ST_ASP : ST_IDLE;
        // MIX continues here after its aspersion phase.
        ST_DRIP:    state_d = (typ == IRR_DRIP || typ == IRR_MIX) ? ST_DRIP : ST_IDLE;
        ST_MIX_ASP: begin
          if (typ != IRR_MIX)          state_d = ST_IDLE;
          else if (sec_tick && tmr_done) state_d = ST_DRIP;
          else                         state_d = ST_MIX_ASP;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign state      = state_q;
  assign valve_asp  = outs_q.asp;
  assign valve_drip = outs_q.drip;
  assign valve_fill = outs_q.fill;
  assign error      = outs_q.err;

endmodule

// File: tb/tb_irrigation_sequencer.sv
module tb_irrigation_sequencer;

  logic       clk, rst_n, init, h_min, h_max;
  logic [1:0] irr_type;
  logic       valve_asp, valve_drip, valve_fill, error;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  irrigation_sequencer #(.TICKS_PER_SEC(4), .ASP_TIME(3), .SEC_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .irr_type  (irr_type),
    .h_min     (h_min),
    .h_max     (h_max),
    .valve_asp (valve_asp),
    .valve_drip(valve_drip),
    .valve_fill(valve_fill),
    .error     (error),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state, asp, drip, fill, error}, written out per state code.
  localparam logic [6:0] E_IDLE = {3'b000, 4'b0000};
  localparam logic [6:0] E_ASP  = {3'b001, 4'b1000};
  localparam logic [6:0] E_DRIP = {3'b010, 4'b0100};
  localparam logic [6:0] E_MIX  = {3'b011, 4'b1000};
  localparam logic [6:0] E_FILL = {3'b100, 4'b0010};
  localparam logic [6:0] E_ERR  = {3'b101, 4'b0001};

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {state, valve_asp, valve_drip, valve_fill, error};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // irr_type=11 already driven in IDLE: 12 clks of aspersion, then drip.
  task automatic mix_phase(input string tag);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk($sformatf("%s_asp%0d", tag, i), E_MIX);
    end
    step(1);
    chk({tag, "_drip"}, E_DRIP);
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; irr_type = 2'b00; h_min = 1'b0; h_max = 1'b0;
    #3;
    chk("reset", E_IDLE);
    #9 rst_n = 1'b1;                  // t=12, between edges

    // 1) plain aspersion
    h_min = 1'b1; h_max = 1'b1; init = 1'b1; irr_type = 2'b01;
    step(1); chk("asp_enter", E_ASP);
    step(1); chk("asp_hold", E_ASP);
    irr_type = 2'b00;
    step(1); chk("asp_exit", E_IDLE);

    // 2) full mix sequence
    irr_type = 2'b11;
    mix_phase("mix1");
    step(1); chk("mix1_drip_hold", E_DRIP);
    irr_type = 2'b00;
    step(1); chk("mix1_exit", E_IDLE);

    // 3) aborted mix restarts from zero
    irr_type = 2'b11;
    step(6); chk("mix_abort_pre", E_MIX);
    irr_type = 2'b00;
    step(1); chk("mix_abort", E_IDLE);
    irr_type = 2'b11;
    mix_phase("mix2");

    // 4) fill interlock from DRIP
    irr_type = 2'b10;
    step(1); chk("drip_hold", E_DRIP);
    h_min = 1'b0; h_max = 1'b0;
    step(1); chk("fill_enter", E_FILL);
    init = 1'b0;
    step(1); chk("fill_no_abort", E_FILL);
    init = 1'b1; h_min = 1'b1;
    step(1); chk("fill_wait_max", E_FILL);
    h_max = 1'b1;
    step(1); chk("fill_done", E_IDLE);
    step(1); chk("drip_again", E_DRIP);

    // 5) sensor error
    h_min = 1'b0; h_max = 1'b1;
    step(1); chk("err_enter", E_ERR);
    h_min = 1'b1;
    step(2); chk("err_hold_init", E_ERR);
    init = 1'b0;
    step(1); chk("err_exit", E_IDLE);
    init = 1'b1; irr_type = 2'b01;
    step(1); chk("post_err_asp", E_ASP);
    h_min = 1'b0;
    step(1); chk("err_from_asp", E_ERR);
    h_min = 1'b1; init = 1'b0;
    step(1); chk("err_exit2", E_IDLE);
    init = 1'b1; irr_type = 2'b00;
    step(1); chk("idle_none", E_IDLE);
    init = 1'b0; irr_type = 2'b10;
    step(1); chk("init_low_idle", E_IDLE);
    init = 1'b1;

    // 6) asynchronous reset mid-MIX_ASP
    irr_type = 2'b11;
    step(5); chk("mix3_pre", E_MIX);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", E_IDLE);
    #2 rst_n = 1'b1;
    mix_phase("mix4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
